quote_scheduler: RTL

Shares one `quote_price` datapath between `NUM_SYMBOLS` per-symbol price feeds. Each feed's latest (ref price, spread) update is kept in a pending slot; a round-robin, per-symbol-throttled arbiter issues one slot at a time to the datapath. The block captures the resulting buy/ask pair and presents it tagged with its symbol ID to the downstream order encoder over a valid/ready handshake.

---
 rtl/quote_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/quote_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/quote_pkg.sv
// Shared types and constants for the quote scheduler and its order-path neighbours.
package quote_pkg;

  localparam int unsigned OVW_W = 16;

  typedef enum logic [1:0] {
    QS_IDLE,
    QS_WAIT,
    QS_HOLD
  } qs_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IW-1:0]]   = 1'b1;
        idx_o                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/quote_scheduler.sv
// Time-shares one quote_price datapath across per-symbol feeds with round-robin,
// per-symbol throttling and a valid/ready quote output.
module quote_scheduler
  import quote_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH      = 32,
  parameter  int unsigned NUM_SYMBOLS     = 4,
  parameter  int unsigned THROTTLE_CYCLES = 16,
  localparam int unsigned SYM_W           = $clog2(NUM_SYMBOLS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_enable,
  input  logic [NUM_SYMBOLS-1:0]            i_upd_valid,
  input  logic [NUM_SYMBOLS*DATA_WIDTH-1:0] i_upd_ref_price,
  input  logic [NUM_SYMBOLS*DATA_WIDTH-1:0] i_upd_spread,
  output logic [DATA_WIDTH-1:0]             o_qp_ref_price,
  output logic [DATA_WIDTH-1:0]             o_qp_spread,
  output logic                              o_qp_data_valid,
  input  logic [DATA_WIDTH-1:0]             i_qp_buy_price,
  input  logic [DATA_WIDTH-1:0]             i_qp_ask_price,
  input  logic                              i_qp_data_valid,
  output logic                              o_quote_valid,
  output logic [SYM_W-1:0]                  o_quote_sym,
  output logic [DATA_WIDTH-1:0]             o_buy_price,
  output logic [DATA_WIDTH-1:0]             o_ask_price,
  input  logic                              i_quote_ready,
  output logic [OVW_W-1:0]                  o_overwrite_cnt
);

  localparam int unsigned TW = $clog2(THROTTLE_CYCLES + 1);

  qs_state_e                 state_q, state_d;
  logic [NUM_SYMBOLS-1:0]    slot_vld_q, slot_vld_d;
  logic [DATA_WIDTH-1:0]     slot_ref_q [NUM_SYMBOLS];
  logic [DATA_WIDTH-1:0]     slot_ref_d [NUM_SYMBOLS];
  logic [DATA_WIDTH-1:0]     slot_spr_q [NUM_SYMBOLS];
  logic [DATA_WIDTH-1:0]     slot_spr_d [NUM_SYMBOLS];
  logic [TW-1:0]             thr_q [NUM_SYMBOLS];
  logic [TW-1:0]             thr_d [NUM_SYMBOLS];
  logic [SYM_W-1:0]          rr_ptr_q, rr_ptr_d, gnt_sym_q, gnt_sym_d;
  logic [DATA_WIDTH-1:0]     qp_ref_q, qp_ref_d, qp_spr_q, qp_spr_d;
  logic                      qp_vld_q, qp_vld_d, q_vld_q, q_vld_d;
  logic [SYM_W-1:0]          q_sym_q, q_sym_d;
  logic [DATA_WIDTH-1:0]     buy_q, buy_d, ask_q, ask_d;
  logic [OVW_W-1:0]          ovw_cnt_q, ovw_cnt_d;

  logic [NUM_SYMBOLS-1:0]    elig, arb_gnt, take, ovw;
  logic [SYM_W-1:0]          arb_idx;
  logic                      issue, hs;
  logic [SYM_W:0]            ovw_num;
  logic [OVW_W:0]            ovw_sum;

  always_comb begin
    for (int unsigned s = 0; s < NUM_SYMBOLS; s++) begin
      elig[s] = slot_vld_q[s] && (thr_q[s] == '0);
    end
  end

  rr_arbiter #(.N(NUM_SYMBOLS)) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign issue = (state_q == QS_IDLE) && i_enable && (|elig);
  assign take  = issue ? arb_gnt : '0;
  assign hs    = (state_q == QS_HOLD) && i_quote_ready;

  // Pending slots: newest update wins; a same-edge update on the granted slot stays pending.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_ref_d = slot_ref_q;
    slot_spr_d = slot_spr_q;
    ovw        = '0;
    for (int unsigned s = 0; s < NUM_SYMBOLS; s++) begin
      if (i_upd_valid[s]) begin
        slot_vld_d[s] = 1'b1;
        slot_ref_d[s] = i_upd_ref_price[s*DATA_WIDTH +: DATA_WIDTH];
        slot_spr_d[s] = i_upd_spread[s*DATA_WIDTH +: DATA_WIDTH];
        ovw[s]        = slot_vld_q[s] && !take[s];
      end else if (take[s]) begin
        slot_vld_d[s] = 1'b0;
      end
    end
  end

  always_comb begin
    ovw_num = '0;
    for (int unsigned s = 0; s < NUM_SYMBOLS; s++) begin
      if (ovw[s]) ovw_num = ovw_num + (SYM_W+1)'(1);
    end
    ovw_sum   = {1'b0, ovw_cnt_q} + (OVW_W+1)'(ovw_num);
    ovw_cnt_d = ovw_sum[OVW_W] ? '1 : ovw_sum[OVW_W-1:0];
  end

  always_comb begin
    for (int unsigned s = 0; s < NUM_SYMBOLS; s++) begin
      thr_d[s] = (thr_q[s] != '0) ? thr_q[s] - TW'(1) : '0;
    end
    if (hs) thr_d[gnt_sym_q] = TW'(THROTTLE_CYCLES);
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_sym_d = gnt_sym_q;
    qp_ref_d  = qp_ref_q;
    qp_spr_d  = qp_spr_q;
    qp_vld_d  = 1'b0;
    q_vld_d   = q_vld_q;
    q_sym_d   = q_sym_q;
    buy_d     = buy_q;
    ask_d     = ask_q;
    unique case (state_q)
      QS_IDLE: begin
        if (issue) begin
          qp_ref_d  = slot_ref_q[arb_idx];
          qp_spr_d  = slot_spr_q[arb_idx];
          qp_vld_d  = 1'b1;
          gnt_sym_d = arb_idx;
          state_d   = QS_WAIT;
        end
      end
      QS_WAIT: begin
        if (i_qp_data_valid) begin
          buy_d   = i_qp_buy_price;
          ask_d   = i_qp_ask_price;
          q_sym_d = gnt_sym_q;
          q_vld_d = 1'b1;
          state_d = QS_HOLD;
        end
      end
      QS_HOLD: begin
        if (hs) begin
          q_vld_d  = 1'b0;
          rr_ptr_d = (gnt_sym_q == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : gnt_sym_q + SYM_W'(1);
          state_d  = QS_IDLE;
        end
      end
      default: state_d = QS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= QS_IDLE;
      slot_vld_q <= '0;
      for (int unsigned s = 0; s < NUM_SYMBOLS; s++) begin
        slot_ref_q[s] <= '0;
        slot_spr_q[s] <= '0;
        thr_q[s]      <= '0;
      end
      rr_ptr_q   <= '0;
      gnt_sym_q  <= '0;
      qp_ref_q   <= '0;
      qp_spr_q   <= '0;
      qp_vld_q   <= 1'b0;
      q_vld_q    <= 1'b0;
      q_sym_q    <= '0;
      buy_q      <= '0;
      ask_q      <= '0;
      ovw_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_vld_q <= slot_vld_d;
      slot_ref_q <= slot_ref_d;
      slot_spr_q <= slot_spr_d;
      thr_q      <= thr_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_sym_q  <= gnt_sym_d;
      qp_ref_q   <= qp_ref_d;
      qp_spr_q   <= qp_spr_d;
      qp_vld_q   <= qp_vld_d;
      q_vld_q    <= q_vld_d;
      q_sym_q    <= q_sym_d;
      buy_q      <= buy_d;
      ask_q      <= ask_d;
      ovw_cnt_q  <= ovw_cnt_d;
    end
  end

  assign o_qp_ref_price  = qp_ref_q;
  assign o_qp_spread     = qp_spr_q;
  assign o_qp_data_valid = qp_vld_q;
  assign o_quote_valid   = q_vld_q;
  assign o_quote_sym     = q_sym_q;
  assign o_buy_price     = buy_q;
  assign o_ask_price     = ask_q;
  assign o_overwrite_cnt = ovw_cnt_q;

endmodule
